pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters SHALL be:
- REG_ID_WIDTH, default 5, register specifier width.
- MEM_TIMEOUT, default 255, MEM wait cycles before timeout flag.
- CNT_WIDTH, default 32, stall counter width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- id_rs1, id_rs2  in  REG_ID_WIDTH  source specifiers of instruction in ID.
- id_rs1_used, id_rs2_used  in  1  each specifier is actually read.
- ex_dest  in  REG_ID_WIDTH  destination of instruction in EX.
- ex_reg_write  in  1  EX instruction writes the register file.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- mem_busy  in  1  MEM-stage access outstanding; data not returned this cycle.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID register.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_stall  out  1  hold ID/EX register.
- id_ex_bubble  out  1  load NOP (control zero) into ID/EX.
- ex_mem_stall  out  1  hold EX/MEM register.
- mem_wb_bubble  out  1  force MEM/WB write-back control to 2'b00.
- pc_redirect  out  1  PC loads branch target this cycle.
- state  out  2  FSM state encoding.
- stall_cycles  out  CNT_WIDTH  saturating count of stalled cycles.
- mem_timeout  out  1  sticky MEM-wait timeout flag.

Function
REQ-003 FSM SHALL have states RUN=0, MEM_WAIT=1, REDIRECT_PEND=2, REDIRECT=3.
REQ-004 Load-use hazard SHALL be ex_mem_read & ex_reg_write & ex_dest!=0 & ((id_rs1_used & id_rs1==ex_dest) | (id_rs2_used & id_rs2==ex_dest)).
REQ-005 A register 0 destination SHALL never cause a hazard.
REQ-006 Outputs SHALL be combinational from current inputs and registered state.
REQ-007 Priority SHALL be: reset > mem_busy > branch (live or pending) > load-use.
REQ-008 RUN with mem_busy=1 SHALL:
- assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_bubble;
- move to MEM_WAIT, or to REDIRECT_PEND if ex_branch_taken=1 in the same cycle.
REQ-009 MEM_WAIT SHALL:
- keep all stall outputs and mem_wb_bubble asserted while mem_busy=1;
- go to RUN with no stall outputs when mem_busy=0.
REQ-010 A taken branch arriving while stalled SHALL:
- be latched as pending, moving MEM_WAIT to REDIRECT_PEND;
- never be dropped.
REQ-011 REDIRECT_PEND SHALL:
- keep stall outputs asserted while mem_busy=1;
- on mem_busy=0, assert pc_redirect, if_id_flush and id_ex_bubble for one cycle and enter REDIRECT.
REQ-012 RUN with ex_branch_taken=1 and mem_busy=0 SHALL:
- assert pc_redirect, if_id_flush and id_ex_bubble that cycle;
- suppress any load-use stall;
- enter REDIRECT.
REQ-013 REDIRECT SHALL:
- last exactly one cycle, asserting id_ex_bubble only, to squash the flushed ID slot;
- return to RUN;
- apply mem_busy per REQ-008 if it is asserted during that cycle.
REQ-014 RUN with a load-use hazard only SHALL assert pc_stall, if_id_stall and id_ex_bubble for one cycle and stay in RUN; the hazard clears on the next cycle as the load leaves EX.
REQ-015 stall_cycles SHALL:
- increment by 1 on every cycle pc_stall=1;
- saturate at all-ones with no wrap.
REQ-016 A wait counter SHALL:
- count consecutive cycles in MEM_WAIT or REDIRECT_PEND with mem_busy=1;
- clear on leaving those states;
- set mem_timeout once it reaches MEM_TIMEOUT; mem_timeout then stays set until reset.
REQ-017 pc_redirect and pc_stall SHALL never be asserted in the same cycle.

Reset
REQ-018 Reset SHALL force state=RUN, clear any pending branch, stall_cycles=0, wait counter=0 and mem_timeout=0.
REQ-019 With reset=1, all stall, flush, bubble and redirect outputs SHALL be 0.
REQ-020 Reset asserted mid MEM_WAIT or REDIRECT_PEND SHALL discard the pending branch; the first cycle after reset is RUN.

Verification
REQ-021 Load x5 in EX, ID reads rs1=5 with id_rs1_used=1 -> one cycle of pc_stall=if_id_stall=id_ex_bubble=1; stall_cycles=1.
REQ-022 Same as REQ-021 but ex_dest=0, or rs1=5 with id_rs1_used=0 -> no stall outputs.
REQ-023 mem_busy=1 for 3 cycles -> 3 cycles of all stalls plus mem_wb_bubble, state=1, then RUN; stall_cycles=3.
REQ-024 ex_branch_taken=1 in cycle 2 of a 4-cycle mem_busy -> pc_redirect=1 exactly once, in the first cycle mem_busy=0; next cycle id_ex_bubble=1, state=3.
REQ-025 Branch and load-use in the same RUN cycle -> pc_redirect=if_id_flush=id_ex_bubble=1, pc_stall=0.
REQ-026 MEM_TIMEOUT=4, mem_busy held 6 cycles -> mem_timeout rises after the 4th busy cycle and remains 1 until reset; reset mid-wait -> state=0, all outputs 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: ID/EX/MEM status inputs and pipeline-register
// control outputs. The pipeline drives through master; the controller uses slave.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ID_WIDTH = 5,
    parameter int CNT_WIDTH    = 32
);
    logic [REG_ID_WIDTH-1:0] id_rs1;
    logic [REG_ID_WIDTH-1:0] id_rs2;
    logic                    id_rs1_used;
    logic                    id_rs2_used;
    logic [REG_ID_WIDTH-1:0] ex_dest;
    logic                    ex_reg_write;
    logic                    ex_mem_read;
    logic                    ex_branch_taken;
    logic                    mem_busy;

    logic                    pc_stall;
    logic                    if_id_stall;
    logic                    if_id_flush;
    logic                    id_ex_stall;
    logic                    id_ex_bubble;
    logic                    ex_mem_stall;
    logic                    mem_wb_bubble;
    logic                    pc_redirect;
    logic [1:0]              state;
    logic [CNT_WIDTH-1:0]    stall_cycles;
    logic                    mem_timeout;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_dest,
               ex_reg_write, ex_mem_read, ex_branch_taken, mem_busy,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
               ex_mem_stall, mem_wb_bubble, pc_redirect, state, stall_cycles,
               mem_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_dest,
               ex_reg_write, ex_mem_read, ex_branch_taken, mem_busy,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
               ex_mem_stall, mem_wb_bubble, pc_redirect, state, stall_cycles,
               mem_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, MEM-wait stalls,
// taken-branch redirect (deferred while MEM is busy), stall statistics and
// a sticky MEM-wait timeout flag.
module pipeline_hazard_ctrl #(
    parameter int REG_ID_WIDTH = 5,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_WIDTH    = 32
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN           = 2'd0,
        MEM_WAIT      = 2'd1,
        REDIRECT_PEND = 2'd2,
        REDIRECT      = 2'd3
    } state_e;

    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    stall_cycles_q, stall_cycles_d;
    logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic                    mem_timeout_q, mem_timeout_d;

    logic [REG_ID_WIDTH-1:0] rs1, rs2, dest;
    logic                    load_use;
    logic                    pc_stall, if_id_stall, if_id_flush, id_ex_stall;
    logic                    id_ex_bubble, ex_mem_stall, mem_wb_bubble, pc_redirect;

    assign rs1  = bus.id_rs1;
    assign rs2  = bus.id_rs2;
    assign dest = bus.ex_dest;

    // Load in EX whose (non-zero) destination is read by the ID instruction
    always_comb begin
        load_use = bus.ex_mem_read && bus.ex_reg_write && (dest != '0) &&
                   ((bus.id_rs1_used && (rs1 == dest)) ||
                    (bus.id_rs2_used && (rs2 == dest)));
    end

    // Next state and pipeline controls; mem_busy outranks branch outranks load-use
    always_comb begin
        state_d       = state_q;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_bubble = 1'b0;
        pc_redirect   = 1'b0;

        if (bus.mem_busy) begin
            // Every busy cycle freezes the front of the pipe whatever the state;
            // a branch seen now is remembered by parking in REDIRECT_PEND.
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
            if (state_q == REDIRECT_PEND || bus.ex_branch_taken)
                state_d = REDIRECT_PEND;
            else
                state_d = MEM_WAIT;
        end else begin
            case (state_q)
                REDIRECT: begin
                    id_ex_bubble = 1'b1;
                    state_d      = RUN;
                end
                REDIRECT_PEND: begin
                    pc_redirect  = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    state_d      = REDIRECT;
                end
                MEM_WAIT: begin
                    // Release from the wait; a branch resolving now is not lost
                    if (bus.ex_branch_taken) begin
                        pc_redirect  = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        state_d      = REDIRECT;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    if (bus.ex_branch_taken) begin
                        pc_redirect  = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        state_d      = REDIRECT;
                    end else if (load_use) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
            endcase
        end

        if (reset) begin
            state_d       = RUN;
            pc_stall      = 1'b0;
            if_id_stall   = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_stall   = 1'b0;
            id_ex_bubble  = 1'b0;
            ex_mem_stall  = 1'b0;
            mem_wb_bubble = 1'b0;
            pc_redirect   = 1'b0;
        end
    end

    // Saturating stall counter and MEM-wait timeout tracking
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (pc_stall && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + 1'b1;

        // The cycle that enters the wait is counted too, so the flag is
        // visible right after the MEM_TIMEOUT-th consecutive busy cycle.
        wait_cnt_d = '0;
        if (bus.mem_busy)
            wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + 1'b1;

        mem_timeout_d = mem_timeout_q || (wait_cnt_d == WAIT_LIMIT);

        if (reset) begin
            stall_cycles_d = '0;
            wait_cnt_d     = '0;
            mem_timeout_d  = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        state_q        <= state_d;
        stall_cycles_q <= stall_cycles_d;
        wait_cnt_q     <= wait_cnt_d;
        mem_timeout_q  <= mem_timeout_d;
    end

    assign bus.pc_stall      = pc_stall;
    assign bus.if_id_stall   = if_id_stall;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.id_ex_stall   = id_ex_stall;
    assign bus.id_ex_bubble  = id_ex_bubble;
    assign bus.ex_mem_stall  = ex_mem_stall;
    assign bus.mem_wb_bubble = mem_wb_bubble;
    assign bus.pc_redirect   = pc_redirect;
    assign bus.state         = state_q;
    assign bus.stall_cycles  = stall_cycles_q;
    assign bus.mem_timeout   = mem_timeout_q;
endmodule
